// File: rtl/pipe_stage_chain.sv
// Parametrised valid/allow_in pipeline backbone with per-stage ready_go and flush,
// exporting stage registers, occupancy and a saturating input-stall counter.
module pipe_stage_chain #(
  parameter int STAGES = 5,
  parameter int WD     = 64,
  parameter int CNT_W  = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         in_valid,
  input  logic [WD-1:0]                in_bus,
  output logic                         in_allow_in,
  input  logic [STAGES-1:0]            ready_go,
  input  logic [STAGES-1:0]            flush,
  output logic                         out_valid,
  output logic [WD-1:0]                out_bus,
  input  logic                         out_allow_in,
  output logic [STAGES-1:0]            stage_valid,
  output logic [STAGES*WD-1:0]         stage_bus,
  output logic [$clog2(STAGES+1)-1:0]  occupancy,
  output logic [CNT_W-1:0]             stall_cnt,
  input  logic                         stall_clr
);

  localparam int OCC_W = $clog2(STAGES+1);

  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] allow;
  logic [STAGES-1:0] kill;
  logic [STAGES-2:0] go;
  logic [STAGES-1:0] src_valid;
  logic [WD-1:0]     bus     [STAGES];
  logic [WD-1:0]     src_bus [STAGES];
  logic              any_flush;
  logic              in_fire;
  logic              stall;
  logic              allow_acc;
  logic              kill_acc;

  // Walk from the oldest stage down: allow ripples from the sink, kill accumulates older flushes.
  always_comb begin
    allow     = '0;
    kill      = '0;
    allow_acc = out_allow_in;
    kill_acc  = 1'b0;
    for (int i = STAGES-1; i >= 0; i--) begin
      allow[i]  = ~valid[i] | (ready_go[i] & allow_acc);
      allow_acc = allow[i];
      kill[i]   = kill_acc;
      kill_acc  = kill_acc | flush[i];
    end
  end

  assign go          = valid[STAGES-2:0] & ready_go[STAGES-2:0] & ~kill[STAGES-2:0];
  assign any_flush   = |flush;
  assign in_allow_in = allow[0] & ~any_flush;
  assign in_fire     = in_valid & in_allow_in;
  assign stall       = in_valid & ~in_allow_in;
  assign src_valid   = {go, in_fire};

  always_comb begin
    src_bus[0] = in_bus;
    for (int i = 1; i < STAGES; i++) begin
      src_bus[i] = bus[i-1];
    end
  end

  // A killed stage drops its beat; the payload only moves when a real beat arrives.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        bus[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (kill[i]) begin
          valid[i] <= 1'b0;
        end else if (allow[i]) begin
          valid[i] <= src_valid[i];
          if (src_valid[i]) begin
            bus[i] <= src_bus[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(valid[i]);
    end
  end

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_flat
      assign stage_bus[g*WD +: WD] = bus[g];
    end
  endgenerate

  assign stage_valid = valid;
  assign out_valid   = valid[STAGES-1] & ready_go[STAGES-1];
  assign out_bus     = bus[STAGES-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (STAGES=5, WD=64, CNT_W=4): streaming, backpressure,
// local stall, flush, asynchronous reset and stall counter saturation.
module tb_pipe_stage_chain;

  logic          clk = 1'b1;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic [63:0]   in_bus = '0;
  logic          in_allow_in;
  logic [4:0]    ready_go = 5'b11111;
  logic [4:0]    flush = '0;
  logic          out_valid;
  logic [63:0]   out_bus;
  logic          out_allow_in = 1'b1;
  logic [4:0]    stage_valid;
  logic [319:0]  stage_bus;
  logic [2:0]    occupancy;
  logic [3:0]    stall_cnt;
  logic          stall_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  pipe_stage_chain #(.STAGES(5), .WD(64), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_bus(in_bus),
    .in_allow_in(in_allow_in), .ready_go(ready_go), .flush(flush),
    .out_valid(out_valid), .out_bus(out_bus), .out_allow_in(out_allow_in),
    .stage_valid(stage_valid), .stage_bus(stage_bus), .occupancy(occupancy),
    .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  int next_beat;
  int exp_cnt;
  logic exp_allow;
  int stall_table [19] = '{0,0,0,0,0,21,22,23,24,0,0,0,25,26,27,28,29,30,0};

  initial begin
    // asynchronous reset, no clock edge yet
    #2;
    check("rst_stage_valid", 64'(stage_valid), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_out_bus", out_bus, 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_allow", 64'(in_allow_in), 64'd1);
    #1 resetn = 1'b1;

    // streaming: beats 1..10 back-to-back
    for (int c = 0; c < 16; c++) begin
      in_valid = (c < 10);
      in_bus   = 64'(c + 1);
      mid();
      check("stream_allow", 64'(in_allow_in), 64'd1);
      check("stream_out_valid", 64'(out_valid), 64'((c >= 5) && (c < 15)));
      if ((c >= 5) && (c < 15)) check("stream_out_bus", out_bus, 64'(c - 4));
      if ((c >= 5) && (c <= 10)) check("stream_occ", 64'(occupancy), 64'd5);
      tick();
    end

    // backpressure: sink blocked, source holds beat 16
    out_allow_in = 1'b0;
    in_valid     = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_bus = 64'(11 + c);
      mid();
      check("bp_fill_allow", 64'(in_allow_in), 64'd1);
      tick();
    end
    in_bus = 64'd16;
    for (int c = 0; c < 4; c++) begin
      mid();
      check("bp_allow", 64'(in_allow_in), 64'd0);
      check("bp_occ", 64'(occupancy), 64'd5);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_bus", out_bus, 64'd11);
      check("bp_stall_cnt", 64'(stall_cnt), 64'(c));
      tick();
    end
    out_allow_in = 1'b1;
    mid();
    check("bp_release_allow", 64'(in_allow_in), 64'd1);
    check("bp_stall_total", 64'(stall_cnt), 64'd4);
    check("bp_release_bus", out_bus, 64'd11);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      mid();
      check("bp_drain_valid", 64'(out_valid), 64'd1);
      check("bp_drain_bus", out_bus, 64'(12 + c));
      tick();
    end
    mid();
    check("bp_empty", 64'(out_valid), 64'd0);
    tick();
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    mid();
    check("clr_stall_cnt", 64'(stall_cnt), 64'd0);
    tick();

    // local stall: ready_go[2] low for three cycles on a full pipe
    next_beat = 21;
    for (int c = 0; c < 19; c++) begin
      ready_go  = ((c >= 7) && (c <= 9)) ? 5'b11011 : 5'b11111;
      in_valid  = (next_beat <= 30);
      in_bus    = 64'(next_beat);
      exp_allow = !((c >= 7) && (c <= 9));
      mid();
      check("ls_allow", 64'(in_allow_in), 64'(exp_allow));
      check("ls_out_valid", 64'(out_valid), 64'(stall_table[c] != 0));
      if (stall_table[c] != 0) check("ls_out_bus", out_bus, 64'(stall_table[c]));
      if (c == 8) check("ls_stage_valid_8", 64'(stage_valid), 64'b10111);
      if (c == 9) check("ls_stage_valid_9", 64'(stage_valid), 64'b00111);
      if (c == 10) check("ls_stall_cnt", 64'(stall_cnt), 64'd3);
      if (in_valid && exp_allow) next_beat++;
      tick();
    end
    in_valid  = 1'b0;
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;

    // flush[2] on a full pipe A..E while F is offered
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_bus   = 64'(10 + c);
      mid();
      tick();
    end
    flush  = 5'b00100;
    in_bus = 64'hF;
    mid();
    check("fl_allow", 64'(in_allow_in), 64'd0);
    check("fl_out_bus", out_bus, 64'hA);
    check("fl_stage0", stage_bus[63:0], 64'hE);
    check("fl_full", 64'(stage_valid), 64'b11111);
    tick();
    flush = '0;
    mid();
    check("fl_stage_valid", 64'(stage_valid), 64'b11000);
    check("fl_next_out_bus", out_bus, 64'hB);
    check("fl_stage3", stage_bus[3*64 +: 64], 64'hC);
    check("fl_occ", 64'(occupancy), 64'd2);
    check("fl_reaccept", 64'(in_allow_in), 64'd1);
    check("fl_stall_cnt", 64'(stall_cnt), 64'd1);
    tick();
    in_valid = 1'b0;
    mid();
    check("fl_after_valid", 64'(stage_valid), 64'b10001);
    check("fl_after_bus", out_bus, 64'hC);
    check("fl_after_stage0", stage_bus[63:0], 64'hF);
    tick();
    for (int c = 8; c < 12; c++) begin
      mid();
      check("fl_drain_valid", 64'(out_valid), 64'(c == 11));
      if (c == 11) check("fl_drain_bus", out_bus, 64'hF);
      tick();
    end

    // asynchronous reset between edges mid-stream
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_bus   = 64'(8'h50 + c);
      mid();
      tick();
    end
    in_bus = 64'h53;
    resetn = 1'b0;
    #1;
    check("ar_stage_valid", 64'(stage_valid), 64'd0);
    check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_occ", 64'(occupancy), 64'd0);
    check("ar_stall_cnt", 64'(stall_cnt), 64'd0);
    check("ar_out_bus", out_bus, 64'd0);
    mid();
    resetn = 1'b1;
    #1;
    check("ar_allow", 64'(in_allow_in), 64'd1);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < 6; c++) begin
      mid();
      check("ar_resume_valid", 64'(out_valid), 64'(c == 5));
      if (c == 5) check("ar_resume_bus", out_bus, 64'h53);
      tick();
    end

    // stall counter saturation at 15, then clear with a concurrent stall
    out_allow_in = 1'b0;
    in_valid     = 1'b1;
    in_bus       = 64'h70;
    for (int c = 0; c < 26; c++) begin
      mid();
      if (c >= 5) begin
        exp_cnt = ((c - 5) > 15) ? 15 : (c - 5);
        check("sat_stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
      end
      tick();
    end
    stall_clr = 1'b1;
    mid();
    check("sat_before_clr", 64'(stall_cnt), 64'd15);
    tick();
    stall_clr = 1'b0;
    mid();
    check("sat_cleared", 64'(stall_cnt), 64'd0);
    tick();
    mid();
    check("sat_resume", 64'(stall_cnt), 64'd1);
    tick();
    out_allow_in = 1'b1;
    in_valid     = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    mid();
    check("sat_drained", 64'(occupancy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised pipeline backbone that generalises the fixed IF/ID/EXE/MEM/WB valid/allow_in handshake into a chain of STAGES stage registers, each WD bits wide.
- Each stage has its own ready_go. Per-stage flush kills younger stages, for example a branch resolved in stage i squashing the fetch side.
- Provides occupancy and a saturating stall counter for hazard and performance debug.
- Sits between a fetch source and a writeback sink. Stage buses are exported so hazard and forwarding logic can read them.

Parameters:
- STAGES, 5, number of stage registers (legal 2..16). Stage 0 is youngest; stage STAGES-1 is oldest.
- WD, 64, payload bus width per stage (>=1).
- CNT_W, 32, stall counter width (>=2).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream beat valid.
- in_bus  in  WD  upstream payload.
- in_allow_in  out  1  upstream may transfer this cycle.
- ready_go  in  STAGES  bit i: stage i has finished its work this cycle.
- flush  in  STAGES  bit i: kill all stages younger than i, and the input.
- out_valid  out  1  oldest stage presents a beat.
- out_bus  out  WD  oldest stage payload.
- out_allow_in  in  1  downstream accepts.
- stage_valid  out  STAGES  valid bit of each stage register.
- stage_bus  out  STAGES*WD  flat payloads; stage i occupies bits [i*WD +: WD].
- occupancy  out  $clog2(STAGES+1)  popcount of stage_valid.
- stall_cnt  out  CNT_W  saturating count of input stall cycles.
- stall_clr  in  1  synchronous clear of stall_cnt.

Behaviour:
- Reset (resetn=0, asynchronous, no clock needed):
  - All stage valid bits, stage buses and stall_cnt go to 0.
  - Consequently out_valid=0, occupancy=0, out_bus=0.
  - On the first edge after resetn rises, stages are still empty: in_allow_in=1 provided flush=0.
- Define kill[j] = OR of flush[STAGES-1 : j+1]. So kill[STAGES-1]=0, and flush[0] affects only the input.
- Define any_flush = OR of all flush bits.
- Handshake (combinational):
  - allow[STAGES] = out_allow_in.
  - allow[i] = ~valid[i] | (ready_go[i] & allow[i+1]).
  - go[i] = valid[i] & ready_go[i] & ~kill[i].
  - in_allow_in = allow[0] & ~any_flush.
  - out_valid = valid[STAGES-1] & ready_go[STAGES-1].
  - out_bus = bus[STAGES-1].
- Stage update at each edge:
  - kill[i]=1: valid[i] <= 0; bus is don't-care (holds).
  - Else if allow[i]: valid[i] <= src_valid, where src_valid is go[i-1] for i>0, and (in_valid & in_allow_in) for i=0.
  - bus[i] loads from the previous stage (or in_bus) only when src_valid=1; otherwise it holds.
  - Else: hold.
- A killed stage never propagates. The next stage loads a bubble if it is allowed.
- Stage k holding flush[k] is itself unaffected and advances normally.
- Simultaneous flush and in_valid: the input is not accepted (in_allow_in=0). The source must re-present the beat.
- Latency: a beat accepted in cycle t is visible on out_valid/out_bus in cycle t+STAGES, when every ready_go=1 and out_allow_in=1. Throughput is one beat per cycle.
- Ordering: beats exit in acceptance order. No beat is duplicated or dropped except by flush.
- stall_cnt:
  - stall_clr=1: stall_cnt <= 0. This has priority over increment.
  - Else increments when in_valid & ~in_allow_in.
  - Saturates at 2^CNT_W-1 (no wrap).
- occupancy reflects the registered valid bits (it lags handshakes by one edge).
- Protocol: once in_valid is raised, the upstream must hold in_valid and in_bus until transfer or flush. The block does not check this.

Test Plan:
- Streaming (STAGES=5, WD=64, all ready_go=1, out_allow_in=1): in_bus=1..10 back-to-back from cycle 0 -> out_valid first in cycle 5 with out_bus=1; then 2..10 on consecutive cycles; occupancy=5 in steady state.
- Backpressure: out_allow_in=0 with in_valid held -> after 5 accepts occupancy=5 and in_allow_in=0; stall_cnt increments by 1 per held cycle (e.g. 4 cycles -> 4). Release -> beats 1..N exit in order with no duplicates.
- Local stall: ready_go[2]=0 for 3 cycles on a full pipe -> stages 3..4 drain; stage 3 fills with bubbles; stages 0..2 hold. Release -> no data lost and a 3-cycle gap appears at the output.
- Flush: full pipe holding beats A..E (stage0=E), assert flush[2] for one cycle with in_valid=1 -> next cycle stage_valid[1:0]=0 and the input is not taken. C moves to stage 3; stage 2 holds a bubble; out_bus=B.
- Async reset mid-stream: drop resetn between edges -> stage_valid=0, out_valid=0, occupancy=0 and stall_cnt=0 immediately. Release -> in_allow_in=1 and normal streaming resumes.
- Saturation (CNT_W=4): hold a stall for 20 cycles -> stall_cnt stops at 15. Then stall_clr=1 together with a stall -> 0 next cycle, then counting resumes at 1.
